// File: rtl/max_net_pkg.sv
// Shared types and constants for the max_net feeder: FSM state encoding, neuron count, float width.
package max_net_pkg;

  localparam int unsigned N_NEURONS = 4;
  localparam int unsigned FP_W      = 32;

  typedef enum logic [1:0] {
    StLoad,
    StStart,
    StWait,
    StResult
  } state_t;

endpackage

// File: rtl/onehot_check.sv
// Combinational winner decode: index of the lowest set bit, and err when the vector is not one-hot.
module onehot_check
  import max_net_pkg::*;
(
  input  logic [N_NEURONS-1:0] vec,
  output logic [1:0]           index,
  output logic                 err
);

  logic [2:0] w_count;
  logic       w_found;

  always_comb begin
    index   = 2'd0;
    w_found = 1'b0;
    w_count = 3'd0;
    for (int i = 0; i < int'(N_NEURONS); i++) begin
      w_count = w_count + 3'(vec[i]);
      if (vec[i] && !w_found) begin
        index   = 2'(i);
        w_found = 1'b1;
      end
    end
    err = (w_count != 3'd1);
  end

endmodule

// File: rtl/max_net_feeder.sv
// Loads four float32 activations into max_net, pulses start, captures the winner at done.
// Optional watchdog on the WAIT state is enabled by defining FEEDER_TIMEOUT_EN.
module max_net_feeder
  import max_net_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FP_W-1:0]      in_data,
  output logic [FP_W-1:0]      x_init_1,
  output logic [FP_W-1:0]      x_init_2,
  output logic [FP_W-1:0]      x_init_3,
  output logic [FP_W-1:0]      x_init_4,
  output logic                 start,
  input  logic                 done,
  input  logic [N_NEURONS-1:0] out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N_NEURONS-1:0] res_winner,
  output logic [1:0]           res_index,
  output logic                 res_err
);

  state_t                 r_state;
  logic [1:0]             r_cnt;
  logic                   r_start;
  logic                   r_res_valid;
  logic [N_NEURONS-1:0]   r_winner;
  logic [1:0]             r_index;
  logic                   r_err;
  logic [FP_W-1:0]        r_x [N_NEURONS];

  logic [1:0]             w_index;
  logic                   w_err;

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WdW-1:0]         r_wd;
`endif

  // Decode the live winner vector so index/err are registered alongside it at done.
  onehot_check u_onehot_check (
    .vec   (out),
    .index (w_index),
    .err   (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StLoad;
      r_cnt       <= 2'd0;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_winner    <= '0;
      r_index     <= 2'd0;
      r_err       <= 1'b0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        r_x[i] <= '0;
      end
`ifdef FEEDER_TIMEOUT_EN
      r_wd        <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        StLoad: begin
          if (in_valid) begin
            r_x[r_cnt] <= in_data;
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= StStart;
              r_start <= 1'b1;
            end
          end
        end
        StStart: begin
          r_state <= StWait;
`ifdef FEEDER_TIMEOUT_EN
          r_wd    <= '0;
`endif
        end
        StWait: begin
          if (done) begin
            r_winner    <= out;
            r_index     <= w_index;
            r_err       <= w_err;
            r_res_valid <= 1'b1;
            r_state     <= StResult;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (r_wd == WdW'(TIMEOUT - 1)) begin
            // Last allowed WAIT cycle elapsed: report an empty, erroneous result.
            r_winner    <= '0;
            r_index     <= 2'd0;
            r_err       <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= StResult;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        StResult: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cnt       <= 2'd0;
            r_state     <= StLoad;
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  assign in_ready   = (r_state == StLoad);
  assign start      = r_start;
  assign res_valid  = r_res_valid;
  assign res_winner = r_winner;
  assign res_index  = r_index;
  assign res_err    = r_err;
  assign x_init_1   = r_x[0];
  assign x_init_2   = r_x[1];
  assign x_init_3   = r_x[2];
  assign x_init_4   = r_x[3];

endmodule

// File: doc/max_net_feeder.md
MAX_NET_FEEDER -- requirements
Module: max_net_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023; the watchdog limit in clk cycles spent in WAIT.
REQ-002 SHALL have port clk, input, 1; the single clock, rising edge.
REQ-003 SHALL have port rst, input, 1; synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1; an IEEE-754 single-precision word is offered on in_data.
REQ-005 SHALL have port in_ready, output, 1; the feeder accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, 32; IEEE-754 single activation, arriving in order x1..x4.
REQ-007 SHALL have ports x_init_1..x_init_4, output, 32 each; activations driven to max_net.
REQ-008 SHALL have port start, output, 1; the max_net start pulse.
REQ-009 SHALL have port done, input, 1; max_net completion.
REQ-010 SHALL have port out, input, 4; the max_net winner vector, bit i = neuron i+1.
REQ-011 SHALL have port res_valid, output, 1; a result is available.
REQ-012 SHALL have port res_ready, input, 1; the consumer takes the result.
REQ-013 SHALL have port res_winner, output, 4; out captured at done.
REQ-014 SHALL have port res_index, output, 2; binary index of the lowest set bit of res_winner.
REQ-015 SHALL have port res_err, output, 1; res_winner is not one-hot, or a timeout occurred.

Function
REQ-016 SHALL implement FSM states LOAD, START, WAIT and RESULT.
REQ-017 LOAD: in_ready=1; each in_valid&in_ready handshake writes in_data to x_init_{cnt+1} and increments the 2-bit cnt; the fourth handshake goes to START.
REQ-018 START: start=1 for exactly one cycle, then go to WAIT; start=0 in every other state.
REQ-019 x_init_1..4 SHALL hold stable from the START cycle until RESULT is left.
REQ-020 WAIT: when done is sampled high, capture out into res_winner and go to RESULT; a done seen outside WAIT is ignored.
REQ-021 res_index SHALL be the lowest set bit of res_winner (0 for the LSB), or 0 when res_winner is 4'b0000.
REQ-022 res_err SHALL be 1 when res_winner is zero or has two or more bits set.
REQ-023 RESULT: res_valid=1; res_winner, res_index and res_err are held stable until res_valid&res_ready; on that handshake go to LOAD with cnt=0.
REQ-024 in_ready SHALL be 0 outside LOAD; in_valid is ignored there and no data is lost, because the source holds it.
REQ-025 Latency: one cycle from the fourth input handshake to start; one cycle from done to res_valid.
REQ-026 res_valid&res_ready in the same cycle res_valid first rises SHALL complete the handshake; the next LOAD cycle has in_ready=1.

Reset
REQ-027 On rst (at any point, including mid-WAIT): state=LOAD, cnt=0, start=0, res_valid=0, res_winner=0, res_index=0, res_err=0, x_init_1..4=0, watchdog=0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 With FEEDER_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle; when it reaches TIMEOUT without done, go to RESULT with res_winner=0 and res_err=1.
REQ-030 Without FEEDER_TIMEOUT_EN: no counter is implemented, TIMEOUT is unused, and WAIT lasts until done or rst.

Structure
REQ-031 A shared package max_net_pkg SHALL hold the FSM state enum, the constant N_NEURONS=4 and the float32 width constant FP_W=32.
REQ-032 One sub-module, onehot_check, SHALL be used: 4-bit input, outputs index[1:0] and err, purely combinational.

Verification
REQ-033 Drive 3E4CCCCD, 3ECCCCCD, 3F19999A, 3F4CCCCD; then done=1 with out=4'b1000 -> x_init_1..4 match the inputs, one start pulse, res_winner=1000, res_index=3, res_err=0.
REQ-034 Hold res_ready=0 for 5 cycles after res_valid -> outputs stay stable, in_ready=0, extra in_valid is ignored; then res_ready=1 -> back to LOAD.
REQ-035 out=4'b0110 at done -> res_index=1, res_err=1; out=4'b0000 -> res_index=0, res_err=1.
REQ-036 Assert rst after 2 of 4 words, then send 4 new words -> only the new words appear on x_init and exactly one start pulse.
REQ-037 FEEDER_TIMEOUT_EN defined, TIMEOUT=10, done never asserted -> res_valid rises after 10 WAIT cycles with res_err=1 and res_winner=0.
REQ-038 A done pulse during LOAD, then a normal run with out=4'b0001 -> the stray pulse is ignored; res_index=0, res_err=0.
